// File: rtl/onehot_switch_encoder.sv
// ----------------------------------------------------------------------------
// onehot_switch_encoder
//
// Debounced one-hot to binary encoder for the user switch bank. The raw
// switch levels are synchronised, a pattern is accepted only once it has been
// stable for DEBOUNCE consecutive cycles, and the accepted pattern is encoded
// as a 1-based binary code (bit k -> k+1). Patterns with two or more switches
// raised are flagged as multi-hot instead of being encoded. A one-cycle event
// pulse marks each newly accepted nonzero code so the LCD control logic acts
// once per user selection.
//
// Parameters:
//   N         number of switch inputs (N >= 2)
//   W         code width (2^W - 1 >= N)
//   DEBOUNCE  stable cycles needed to accept a pattern (DEBOUNCE >= 1)
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  asynchronous active-high reset
//   sw_in      in   N  raw switch levels, asynchronous to clk
//   code       out  W  accepted code, 0 when no valid single selection
//   valid      out  1  high while a single-switch pattern is accepted
//   multi_hot  out  1  high while the accepted pattern has >= 2 bits set
//   new_code   out  1  one-cycle pulse when a new nonzero code is accepted
//   settling   out  1  high while the synchronised input differs from the
//                      accepted pattern
// ----------------------------------------------------------------------------
module onehot_switch_encoder #(
    parameter int N        = 18,
    parameter int W        = 5,
    parameter int DEBOUNCE = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_in,
    output logic [W-1:0] code,
    output logic         valid,
    output logic         multi_hot,
    output logic         new_code,
    output logic         settling
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_PRE = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FAULT  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Input path and stability tracking
    logic [N-1:0]  s1_q, s1_d;
    logic [N-1:0]  s2_q, s2_d;
    logic [N-1:0]  s_prev_q, s_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Accepted pattern and control state
    logic [N-1:0]  q_q, q_d;
    state_t        state_q, state_d;

    // Registered outputs
    logic [W-1:0]  code_q, code_d;
    logic          valid_q, valid_d;
    logic          multi_hot_q, multi_hot_d;
    logic          new_code_q, new_code_d;
    logic          settling_q, settling_d;

    // Classification of the synchronised pattern
    logic [1:0]    hot_count;
    logic [W-1:0]  hot_code;
    logic          qual;

    // Two-flop synchroniser followed by a one-cycle delayed copy used to
    // detect changes of the synchronised value.
    always_comb begin
        s1_d     = sw_in;
        s2_d     = s1_q;
        s_prev_d = s2_q;
    end

    // Stability counter: any change restarts the count from zero, otherwise
    // it climbs to DEBOUNCE and stays there so a steady input never
    // re-qualifies.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_q != s_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Qualification happens only on the single edge where the counter steps
    // from DEBOUNCE-1 to DEBOUNCE.
    always_comb begin
        qual = (s2_q == s_prev_q) && (cnt_q == CNT_PRE);
    end

    // Count set bits (saturating at two, which is all the classifier needs)
    // and remember the 1-based code of the set bit. For a one-hot pattern the
    // last set bit is the only one, so hot_code is exact in that case.
    always_comb begin
        hot_count = 2'd0;
        hot_code  = '0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i]) begin
                if (hot_count != 2'd2) begin
                    hot_count = hot_count + 2'd1;
                end
                hot_code = W'(i + 1);
            end
        end
    end

    // Next state and output values. Outputs change only on a qualification
    // event, so they hold whatever the previous stable state showed while in
    // SETTLE. new_code compares against the code held before SETTLE, which
    // suppresses the pulse when the user returns to the same switch.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        code_d      = code_q;
        valid_d     = valid_q;
        multi_hot_d = multi_hot_q;
        new_code_d  = 1'b0;
        settling_d  = (state_q == SETTLE);

        if (qual) begin
            q_d = s2_q;
            case (hot_count)
                2'd0: begin
                    state_d     = IDLE;
                    code_d      = '0;
                    valid_d     = 1'b0;
                    multi_hot_d = 1'b0;
                end
                2'd1: begin
                    state_d     = HOLD;
                    code_d      = hot_code;
                    valid_d     = 1'b1;
                    multi_hot_d = 1'b0;
                    new_code_d  = (hot_code != code_q);
                end
                default: begin
                    state_d     = FAULT;
                    code_d      = '0;
                    valid_d     = 1'b0;
                    multi_hot_d = 1'b1;
                end
            endcase
        end else if (s2_q != q_q) begin
            state_d = SETTLE;
        end
    end

    // State register. Reset leaves the counter saturated so that a steady
    // zero input after release never produces a qualification event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s_prev_q    <= '0;
            cnt_q       <= CNT_MAX;
            q_q         <= '0;
            state_q     <= IDLE;
            code_q      <= '0;
            valid_q     <= 1'b0;
            multi_hot_q <= 1'b0;
            new_code_q  <= 1'b0;
            settling_q  <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s_prev_q    <= s_prev_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            state_q     <= state_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            multi_hot_q <= multi_hot_d;
            new_code_q  <= new_code_d;
            settling_q  <= settling_d;
        end
    end

    assign code      = code_q;
    assign valid     = valid_q;
    assign multi_hot = multi_hot_q;
    assign new_code  = new_code_q;
    assign settling  = settling_q;

endmodule
